// File: rtl/dds_mc_pkg.sv
// Shared constants and helpers for the time-multiplexed NCO: pipeline depth,
// quadrant folding and the elaboration-time quarter-wave table generator.
package dds_mc_pkg;

    localparam int PIPE_DEPTH = 5;
    localparam int FOLD_AW    = 16;

    // Fixed-point scale for table generation (Q28)
    localparam longint ONE_Q28 = 64'sd268435456;
    localparam longint PI_Q28  = 64'sd843314857;

    typedef struct packed {
        logic [FOLD_AW-1:0] sin_addr;
        logic [FOLD_AW-1:0] cos_addr;
        logic               sin_neg;
        logic               cos_neg;
    } fold_t;

    function automatic int ch_width(int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Odd quadrants read the mirrored address; sign follows the quadrant.
    function automatic fold_t quad_fold(logic [1:0] q, logic [FOLD_AW-1:0] a, int aw);
        fold_t              f;
        logic [FOLD_AW-1:0] na;
        na         = ~a & ((FOLD_AW'(1) << aw) - FOLD_AW'(1));
        f.sin_addr = q[0] ? na : a;
        f.cos_addr = q[0] ? a : na;
        f.sin_neg  = q[1];
        f.cos_neg  = q[1] ^ q[0];
        return f;
    endfunction

    // round(sin(2*pi*(k+0.5)/2^pw) * (2^(mpr-1)-1)) via integer Taylor series
    function automatic int qsin_entry(int k, int pw, int mpr);
        longint th;
        longint term;
        longint sum;
        longint amp;
        th   = (PI_Q28 * longint'(2 * k + 1)) / (longint'(1) << pw);
        term = th;
        sum  = th;
        for (int n = 1; n <= 12; n++) begin
            term = -((((term * th) / ONE_Q28) * th) / ONE_Q28) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) << (mpr - 1)) - 1;
        return int'((sum * amp + ONE_Q28 / 2) / ONE_Q28);
    endfunction

endpackage

// File: rtl/dds_qlut.sv
// Dual-read registered quarter-wave sine ROM; contents are fixed at elaboration
// so both read ports see an identical table.
module dds_qlut
    import dds_mc_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b
);

    logic [DW-1:0] rom [2**AW];

    for (genvar k = 0; k < 2**AW; k++) begin : g_rom
        localparam logic [DW-1:0] ENTRY = DW'(qsin_entry(k, AW + 2, DW + 1));
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/dds_mc_nco.sv
// Multi-channel NCO: one channel slot per enabled cycle, five-stage pipeline
// from accumulator read to signed quadrature output.
module dds_mc_nco
    import dds_mc_pkg::*;
#(
    parameter int  NCH = 4,
    parameter int  APR = 32,
    parameter int  PW  = 12,
    parameter int  MPR = 10,
    localparam int CW  = ch_width(NCH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  cfg_wr,
    input  logic                  cfg_sel,
    input  logic [CW-1:0]         cfg_ch,
    input  logic [APR-1:0]        cfg_data,
    input  logic                  sym_valid,
    input  logic [CW-1:0]         sym_ch,
    input  logic                  sym_bit,
    input  logic                  phase_clr,
    output logic signed [MPR-1:0] fsin_o,
    output logic signed [MPR-1:0] fcos_o,
    output logic [CW-1:0]         out_ch,
    output logic                  out_valid,
    output logic                  sym_drop
);

    localparam int AW = PW - 2;
    localparam int DW = MPR - 1;

    logic [APR-1:0] acc [NCH];
    logic [APR-1:0] inc [NCH];
    logic [APR-1:0] off [NCH];
    logic [CW-1:0]  ch_cnt;

    logic sym_hit;
    logic sym_collide;

    logic [PIPE_DEPTH-1:0] vld;
    logic [APR-1:0]        s1_acc;
    logic [APR-1:0]        s1_off;
    logic [CW-1:0]         s1_ch;
    logic [CW-1:0]         s2_ch;
    logic [CW-1:0]         s3_ch;
    logic [CW-1:0]         s4_ch;
    logic [PW-1:0]         s2_phase;
    logic [AW-1:0]         s3_sin_addr;
    logic [AW-1:0]         s3_cos_addr;
    logic                  s3_sin_neg;
    logic                  s3_cos_neg;
    logic                  s4_sin_neg;
    logic                  s4_cos_neg;
    logic [DW-1:0]         lut_sin;
    logic [DW-1:0]         lut_cos;
    logic [MPR-1:0]        sin_mag;
    logic [MPR-1:0]        cos_mag;
    fold_t                 fold;
    logic                  fold_unused;

    assign sym_hit     = sym_valid & sym_bit;
    assign sym_collide = sym_hit & cfg_wr & cfg_sel & (cfg_ch == sym_ch);

    // Config and symbol updates run every cycle regardless of clken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                inc[i] <= '0;
                off[i] <= '0;
            end
            sym_drop <= 1'b0;
        end else begin
            sym_drop <= sym_collide;
            if (sym_hit && !sym_collide) begin
                off[sym_ch][APR-1] <= ~off[sym_ch][APR-1];
            end
            if (cfg_wr) begin
                if (cfg_sel) begin
                    off[cfg_ch] <= cfg_data;
                end else begin
                    inc[cfg_ch] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        fold = quad_fold(s2_phase[PW-1:PW-2], FOLD_AW'(s2_phase[PW-3:0]), AW);
    end

    assign fold_unused = ^{fold.sin_addr[FOLD_AW-1:AW], fold.cos_addr[FOLD_AW-1:AW]};

    assign sin_mag   = {1'b0, lut_sin};
    assign cos_mag   = {1'b0, lut_cos};
    assign out_valid = vld[PIPE_DEPTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
            ch_cnt      <= '0;
            vld         <= '0;
            s1_acc      <= '0;
            s1_off      <= '0;
            s1_ch       <= '0;
            s2_ch       <= '0;
            s3_ch       <= '0;
            s4_ch       <= '0;
            s2_phase    <= '0;
            s3_sin_addr <= '0;
            s3_cos_addr <= '0;
            s3_sin_neg  <= 1'b0;
            s3_cos_neg  <= 1'b0;
            s4_sin_neg  <= 1'b0;
            s4_cos_neg  <= 1'b0;
            fsin_o      <= '0;
            fcos_o      <= '0;
            out_ch      <= '0;
        end else if (clken) begin
            ch_cnt <= ch_cnt + CW'(1);
            if (phase_clr) begin
                for (int i = 0; i < NCH; i++) begin
                    acc[i] <= '0;
                end
            end else begin
                acc[ch_cnt] <= acc[ch_cnt] + inc[ch_cnt];
            end
            vld <= {vld[PIPE_DEPTH-2:0], 1'b1};

            s1_acc <= acc[ch_cnt];
            s1_off <= off[ch_cnt];
            s1_ch  <= ch_cnt;

            s2_phase <= PW'((s1_acc + s1_off) >> (APR - PW));
            s2_ch    <= s1_ch;

            s3_sin_addr <= fold.sin_addr[AW-1:0];
            s3_cos_addr <= fold.cos_addr[AW-1:0];
            s3_sin_neg  <= fold.sin_neg;
            s3_cos_neg  <= fold.cos_neg;
            s3_ch       <= s2_ch;

            s4_sin_neg <= s3_sin_neg;
            s4_cos_neg <= s3_cos_neg;
            s4_ch      <= s3_ch;

            // Outputs keep their reset value until the first real sample lands.
            if (vld[PIPE_DEPTH-2]) begin
                fsin_o <= s4_sin_neg ? -sin_mag : sin_mag;
                fcos_o <= s4_cos_neg ? -cos_mag : cos_mag;
                out_ch <= s4_ch;
            end
        end
    end

    dds_qlut #(
        .AW (AW),
        .DW (DW)
    ) u_qlut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clken),
        .addr_a  (s3_sin_addr),
        .addr_b  (s3_cos_addr),
        .data_a  (lut_sin),
        .data_b  (lut_cos)
    );

endmodule
